// File: rtl/serial_subtractor64_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// FSM state encoding and default datapath width.
package serial_subtractor64_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subState_t;

endpackage

// File: rtl/serial_subtractor64_full_subtractor.sv
// One-bit full subtractor cell: x - y - borrow_in.
// Purely combinational; reused every cycle by the serial datapath.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  logic xy;

  // difference and borrow of a single bit position
  always_comb begin
    xy         = x ^ y;
    diff       = xy ^ borrow_in;
    borrow_out = (~x & y) | (~xy & borrow_in);
  end

endmodule

// File: rtl/serial_subtractor64.sv
// Bit-serial two's-complement subtractor, LSB first.
// One full-subtractor cell, WIDTH cycles per operation.
module serial_subtractor64
  import serial_subtractor64_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  subState_t        state;
  subState_t        stateNext;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] diffReg;
  logic [CNT_W-1:0] bitCnt;
  logic             bor;
  logic             aMsb;
  logic             bMsb;
  logic             borReg;
  logic             ovfReg;
  logic             dBit;
  logic             borNext;
  logic             accept;
  logic             lastBit;

  full_subtractor uCell (
    .x          (aReg[0]),
    .y          (bReg[0]),
    .borrow_in  (bor),
    .diff       (dBit),
    .borrow_out (borNext)
  );

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign accept       = start_valid & start_ready;
  assign lastBit      = (bitCnt == CNT_W'(WIDTH - 1));
  assign difference   = diffReg;
  assign borrow_out   = borReg;
  assign overflow     = ovfReg;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // next-state logic for the accept / run / hold cycle
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (accept) stateNext = RUN;
      RUN:  if (lastBit) stateNext = DONE;
      DONE: if (result_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // operand capture, serial shift and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg    <= '0;
      bReg    <= '0;
      diffReg <= '0;
      bitCnt  <= '0;
      bor     <= 1'b0;
      aMsb    <= 1'b0;
      bMsb    <= 1'b0;
      borReg  <= 1'b0;
      ovfReg  <= 1'b0;
    end else if (accept) begin
      aReg   <= minuend;
      bReg   <= subtrahend;
      bor    <= borrow_in;
      aMsb   <= minuend[WIDTH-1];
      bMsb   <= subtrahend[WIDTH-1];
      bitCnt <= '0;
    end else if (state == RUN) begin
      aReg    <= aReg >> 1;
      bReg    <= bReg >> 1;
      bor     <= borNext;
      diffReg <= {dBit, diffReg[WIDTH-1:1]};
      bitCnt  <= bitCnt + CNT_W'(1);
      if (lastBit) begin
        borReg <= borNext;
        ovfReg <= (aMsb != bMsb) & (dBit != aMsb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor64.sv
// Randomized self-checking bench for serial_subtractor64.
// Reference: wide integer arithmetic on A - B - borrow_in.
module tb_serial_subtractor64;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         borrow_in;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] difference;
  logic         borrow_out;
  logic         overflow;

  int nChecks = 0;
  int nErrors = 0;

  serial_subtractor64 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .minuend      (minuend),
    .subtrahend   (subtrahend),
    .borrow_in    (borrow_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .difference   (difference),
    .borrow_out   (borrow_out),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // reference: unsigned and signed views of A - B - bin
  task automatic refModel(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bo,
    output logic         ov
  );
    logic [W:0]          u;
    logic signed [W+1:0] s;
    logic signed [W+1:0] maxS;
    logic signed [W+1:0] minS;
    u    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = u[W-1:0];
    bo   = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
    s    = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b})
         - $signed({{(W+1){1'b0}}, bin});
    maxS = $signed({2'b00, 1'b0, {(W-1){1'b1}}});
    minS = -maxS - 1;
    ov   = (s > maxS) || (s < minS);
  endtask

  task automatic runOp(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         bin,
    input int           hold,
    input bit           pulse
  );
    logic [W-1:0] expD;
    logic         expB;
    logic         expO;
    int           lat;
    refModel(a, b, bin, expD, expB, expO);
    @(negedge clk);
    checkVal("startReady", 64'(start_ready), 64'd1);
    minuend     = a;
    subtrahend  = b;
    borrow_in   = bin;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    minuend     = 64'($urandom) << 32 | 64'($urandom);
    subtrahend  = ~minuend;
    borrow_in   = ~bin;
    lat = 0;
    for (int i = 1; i <= W + 10; i++) begin
      if (pulse && i == 20) start_valid = 1'b1;
      if (pulse && i == 21) start_valid = 1'b0;
      @(posedge clk);
      #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    checkVal("latency", 64'(lat), 64'(W));
    checkVal("difference", difference, expD);
    checkVal("borrowOut", 64'(borrow_out), 64'(expB));
    checkVal("overflow", 64'(overflow), 64'(expO));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkVal("holdValid", 64'(result_valid), 64'd1);
      checkVal("holdDiff", difference, expD);
      checkVal("holdBorrow", 64'(borrow_out), 64'(expB));
      checkVal("holdOvf", 64'(overflow), 64'(expO));
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    checkVal("idleValid", 64'(result_valid), 64'd0);
    checkVal("idleReady", 64'(start_ready), 64'd1);
    if (pulse) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        checkVal("noSecondOp", 64'(start_ready), 64'd1);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    start_valid  = 1'b0;
    minuend      = '0;
    subtrahend   = '0;
    borrow_in    = 1'b0;
    result_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkVal("rstValid", 64'(result_valid), 64'd0);
    checkVal("rstDiff", difference, 64'd0);
    checkVal("rstBorrow", 64'(borrow_out), 64'd0);
    checkVal("rstOvf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkVal("rstReady", 64'(start_ready), 64'd1);

    runOp(64'd5, 64'd3, 1'b0, 0, 1'b0);
    runOp(64'd0, 64'd1, 1'b0, 0, 1'b0);
    runOp(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0);
    runOp(64'd10, 64'd3, 1'b1, 0, 1'b0);
    runOp(64'd0, 64'd0, 1'b1, 0, 1'b0);
    runOp(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10, 1'b0);
    runOp(64'd77, 64'd12, 1'b0, 2, 1'b1);

    // abort mid-run with an asynchronous reset
    @(negedge clk);
    minuend     = 64'hDEAD_BEEF_0123_4567;
    subtrahend  = 64'd3;
    borrow_in   = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("abortValid", 64'(result_valid), 64'd0);
    checkVal("abortDiff", difference, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkVal("abortReady", 64'(start_ready), 64'd1);
    runOp(64'd100, 64'd58, 1'b0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = {32'($urandom), 32'($urandom)};
      rb = {32'($urandom), 32'($urandom)};
      if (r % 4 == 0) rb = ra;
      if (r % 5 == 1) rb[W-1] = ~ra[W-1];
      runOp(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor64.md
Name: serial_subtractor64

Overview:
Bit-serial two's-complement subtractor. It computes minuend − subtrahend − borrow_in one bit per clock, LSB first, using a single full-subtractor cell. It is the inverse counterpart of the team's ripple full-adder datapath. It serves area-constrained ALU paths where 64-cycle latency is acceptable, with valid/ready handshakes on both the operand side and the result side.

Parameters:
WIDTH, 64, operand/result width in bits; legal range ≥ 2.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start_valid  input  1  operands and borrow_in are valid.
start_ready  output  1  block can accept operands; high only in IDLE.
minuend  input  WIDTH  operand A.
subtrahend  input  WIDTH  operand B.
borrow_in  input  1  initial borrow into bit 0.
result_valid  output  1  difference, borrow_out and overflow are valid; high only in DONE.
result_ready  input  1  consumer accepts the result.
difference  output  WIDTH  A − B − borrow_in, modulo 2^WIDTH.
borrow_out  output  1  borrow out of the MSB; 1 iff unsigned A < B + borrow_in.
overflow  output  1  signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; start_ready = 1 after reset is released; result_valid = 0; difference = 0; borrow_out = 0; overflow = 0; bit counter = 0; internal shift registers = 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation with no result. The block is in IDLE on the first edge after rst_n rises.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE→RUN on start_valid & start_ready at a rising edge (the accept edge). On that edge: latch A and B into shift registers, latch borrow_in into the borrow flop, latch A[MSB] and B[MSB] for overflow, clear the counter.
  - RUN: each edge computes d = a0 ^ b0 ^ bor and bor' = (~a0 & b0) | (~(a0 ^ b0) & bor). It shifts A and B right by one, shifts d into difference at the MSB end, and increments the counter.
  - RUN→DONE on the edge that processes bit WIDTH−1. On that edge: borrow_out = final bor'; overflow = (A_msb != B_msb) & (d_msb != A_msb).
  - DONE→IDLE on result_valid & result_ready at a rising edge.
- Latency: result_valid rises exactly WIDTH rising edges after the accept edge (64 for the default).
- Throughput: one operation per WIDTH+2 cycles minimum. A new operand cannot be accepted in the same cycle as the result handshake.
- start_ready is combinational from state only. It never depends on start_valid.
- Operand inputs are sampled only on the accept edge. Changes at any other time are ignored.
- Backpressure: in DONE, difference, borrow_out and overflow are held stable for as long as result_ready is low, with no cycle limit.
- Outside DONE, difference is a working register. Its value is unspecified to the consumer until result_valid is high. borrow_out and overflow keep their previous result until the next RUN→DONE transition.
- All registers use the asynchronous reset only. There is no synchronous clear.

Decomposition:
- Shared package holds the FSM state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the default WIDTH constant (64).
- Sub-module full_subtractor is purely combinational.
  - Inputs: x, y, borrow_in.
  - Outputs: diff, borrow_out.
  - Instantiated once, on the LSBs of the shift registers and the borrow flop.
- FSM, counter and shift registers live in serial_subtractor64.

Test Plan:
- Basic: A = 5, B = 3, borrow_in = 0 → difference = 2, borrow_out = 0, overflow = 0. result_valid rises exactly 64 edges after the accept edge.
- Unsigned wrap: A = 0, B = 1 → difference = 0xFFFF_FFFF_FFFF_FFFF, borrow_out = 1, overflow = 0.
- Signed overflow: A = 0x8000_0000_0000_0000, B = 1 → difference = 0x7FFF_FFFF_FFFF_FFFF, borrow_out = 0, overflow = 1.
- Borrow-in chain:
  - A = 10, B = 3, borrow_in = 1 → difference = 6, borrow_out = 0.
  - A = B = 0, borrow_in = 1 → difference = all ones, borrow_out = 1.
- Handshake:
  - Hold result_ready low for 10 cycles in DONE → outputs stable and result_valid held high.
  - Assert result_ready → IDLE on the next edge, with start_ready = 1.
  - start_valid pulsed during RUN → ignored; no second operation occurs.
- Reset mid-operation:
  - Drop rst_n after 30 RUN cycles → result_valid = 0 and difference = 0 immediately, start_ready = 1 after release.
  - Follow with A = 100, B = 58 → difference = 42.
